mem_port_arbiter: RTL

- Round-robin arbiter sharing the central_memory data port (rdaddress_D / wraddress_D / r_dena / wr_dena / data_in / q_D) between two masters:
  - requester 0: CPU load/store unit
  - requester 1: DMA / image-processing engine
- Issues at most one access per cycle, registers the memory control signals and tags each read so the returned q_D goes back to the requester that issued it.
- Sits between the masters and central_memory. The instruction port (address_I) and output port (rdaddress_O) stay unarbitrated.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/rd_tag_pipe.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master central_memory data-port arbiter.
package mem_arb_pkg;

  localparam int unsigned NUM_REQ = 2;

  // Requester 0 is the CPU load/store unit, requester 1 the DMA/image engine.
  typedef logic [0:0] req_id_t;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  // Travels alongside an issued read so q_D can be routed back to its issuer.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

  function automatic req_id_t other_id(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Shift register of read tags matching the memory read latency plus the
// issue register stage; cleared synchronously so in-flight reads are dropped.
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tag_valid_i,
  input  logic tag_id_i,
  output logic tag_valid_o,
  output logic tag_id_o
);

  rd_tag_t stage_q [DEPTH];
  rd_tag_t stage_d [DEPTH];

  // Next stage contents: new tag enters at the head, the rest shift by one.
  always_comb begin
    stage_d[0].valid = tag_valid_i;
    stage_d[0].id    = tag_id_i;
    for (int i = 1; i < int'(DEPTH); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Tag storage with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign tag_valid_o = stage_q[DEPTH-1].valid;
  assign tag_id_o    = stage_q[DEPTH-1].id;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the central_memory data port between the CPU
// load/store unit (requester 0) and the DMA/image engine (requester 1).
// Grants are combinational; memory controls are registered; reads are tagged
// so q_D returns to the requester that issued them.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MEM_DEPTH = 32'h60000,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             lock0,
  input  logic             lock1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic             err0,
  output logic             err1,
  output logic [WIDTH-1:0] rdaddress_D,
  output logic [WIDTH-1:0] wraddress_D,
  output logic             r_dena,
  output logic             wr_dena,
  output logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] q_D
);

  localparam logic [WIDTH-1:0] DepthW = WIDTH'(MEM_DEPTH);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] lock;

  assign req  = {req1, req0};
  assign lock = {lock1, lock0};

  arb_state_e state_q, state_d;
  req_id_t    last_gnt_q, last_gnt_d;
  req_id_t    gnt_id;
  logic       gnt_any;

  logic             sel_we;
  logic [WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0] sel_wdata;
  logic             sel_oor;

  logic               r_dena_q, r_dena_d;
  logic               wr_dena_q, wr_dena_d;
  logic [WIDTH-1:0]   rdaddress_q, rdaddress_d;
  logic [WIDTH-1:0]   wraddress_q, wraddress_d;
  logic [WIDTH-1:0]   data_in_q, data_in_d;
  logic [NUM_REQ-1:0] err_q, err_d;

  logic tag_valid;
  logic tag_id;

  // Arbitration and lock FSM next state. No grant is given while reset is
  // high, since the access would be wiped by the reset edge anyway.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = last_gnt_q;
    if (!reset) begin
      unique case (state_q)
        ARB_LOCKED: begin
          // Owner keeps the port; the other side waits even if owner is idle.
          gnt_any = req[last_gnt_q];
        end
        ARB_IDLE: begin
          if (req0 && req1) begin
            gnt_any = 1'b1;
            gnt_id  = other_id(last_gnt_q);
          end else if (req0) begin
            gnt_any = 1'b1;
            gnt_id  = 1'b0;
          end else if (req1) begin
            gnt_any = 1'b1;
            gnt_id  = 1'b1;
          end
        end
        default: ;
      endcase
    end

    state_d    = ARB_IDLE;
    last_gnt_d = last_gnt_q;
    if (gnt_any) begin
      last_gnt_d = gnt_id;
      if (lock[gnt_id]) begin
        state_d = ARB_LOCKED;
      end
    end
  end

  // Select the granted requester's access attributes.
  always_comb begin
    if (gnt_id == 1'b1) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end else begin
      sel_we    = we0;
      sel_addr  = addr0;
      sel_wdata = wdata0;
    end
    sel_oor = (sel_addr >= DepthW);
  end

  // Memory control next state; out-of-range accesses are granted but only
  // raise err, never an enable. Address/data registers hold when idle.
  always_comb begin
    r_dena_d    = 1'b0;
    wr_dena_d   = 1'b0;
    rdaddress_d = rdaddress_q;
    wraddress_d = wraddress_q;
    data_in_d   = data_in_q;
    err_d       = '0;
    if (gnt_any) begin
      if (sel_oor) begin
        err_d[gnt_id] = 1'b1;
      end else if (sel_we) begin
        wr_dena_d   = 1'b1;
        wraddress_d = sel_addr;
        data_in_d   = sel_wdata;
      end else begin
        r_dena_d    = 1'b1;
        rdaddress_d = sel_addr;
      end
    end
  end

  // Arbiter state and registered memory controls.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      last_gnt_q  <= 1'b1;
      r_dena_q    <= 1'b0;
      wr_dena_q   <= 1'b0;
      rdaddress_q <= '0;
      wraddress_q <= '0;
      data_in_q   <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      r_dena_q    <= r_dena_d;
      wr_dena_q   <= wr_dena_d;
      rdaddress_q <= rdaddress_d;
      wraddress_q <= wraddress_d;
      data_in_q   <= data_in_d;
      err_q       <= err_d;
    end
  end

  // One stage for the issue register plus RD_LAT for the memory itself.
  rd_tag_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_rd_tag_pipe (
    .clk_i       (clock),
    .rst_i       (reset),
    .tag_valid_i (r_dena_d),
    .tag_id_i    (gnt_id),
    .tag_valid_o (tag_valid),
    .tag_id_o    (tag_id)
  );

  assign gnt0 = gnt_any && (gnt_id == 1'b0);
  assign gnt1 = gnt_any && (gnt_id == 1'b1);

  assign rvalid0 = tag_valid && (tag_id == 1'b0);
  assign rvalid1 = tag_valid && (tag_id == 1'b1);
  assign rdata0  = rvalid0 ? q_D : '0;
  assign rdata1  = rvalid1 ? q_D : '0;

  assign err0        = err_q[0];
  assign err1        = err_q[1];
  assign r_dena      = r_dena_q;
  assign wr_dena     = wr_dena_q;
  assign rdaddress_D = rdaddress_q;
  assign wraddress_D = wraddress_q;
  assign data_in     = data_in_q;

endmodule
